// File: rtl/data_mem_responder.sv
// Purpose : load/store responder for the core data port; one request in flight, RV32I byte/half/word access with error flagging.
// Latency : rsp_valid rises LATENCY cycles after the request accept edge (LATENCY 1..15).
// Backpr. : req_ready is low from accept until the response handshake; the response holds stable while rsp_ready is low.
// Ports   : clk/reset (async active-low); req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata request side;
//           rsp_valid/rsp_ready/rsp_rdata/rsp_err response side.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]  cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        access;

    logic [31:0] mem [DEPTH];

    // Decode of the latched request
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              out_of_range;
    logic              bad_f3;
    logic              misaligned;
    logic              err;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;
    logic [3:0]        st_be;
    logic [31:0]       st_data;
    logic              mem_we;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // With LATENCY=1 the counter is loaded with 0, so the first
                // BUSY edge is already the access edge.
                if (cnt == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter, response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            f3_q      <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= LAT_M1;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_rdata <= (err || we_q) ? 32'd0 : load_data;
                rsp_err   <= err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address / funct3 decode
    // ------------------------------------------------------------------
    always_comb begin
        word_idx     = addr_q[ADDR_W+1:2];
        lane         = addr_q[1:0];
        out_of_range = |addr_q[31:ADDR_W+2];
        bad_f3       = 1'b0;
        misaligned   = 1'b0;
        if (we_q) begin
            case (f3_q)
                3'b000:  misaligned = 1'b0;
                3'b001:  misaligned = lane[0];
                3'b010:  misaligned = |lane;
                default: bad_f3     = 1'b1;
            endcase
        end else begin
            case (f3_q)
                3'b000, 3'b100: misaligned = 1'b0;
                3'b001, 3'b101: misaligned = lane[0];
                3'b010:         misaligned = |lane;
                default:        bad_f3     = 1'b1;
            endcase
        end
        err = bad_f3 | misaligned | out_of_range;
    end

    // ------------------------------------------------------------------
    // Load extraction and extension
    // ------------------------------------------------------------------
    always_comb begin
        rd_word   = mem[word_idx];
        rd_byte   = rd_word[{lane, 3'b000} +: 8];
        rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = 32'd0;
        case (f3_q)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'd0, rd_half};
            3'b010:  load_data = rd_word;
            default: load_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store lane enables; data is replicated so every lane sees its bytes
    // ------------------------------------------------------------------
    always_comb begin
        st_be   = 4'b0000;
        st_data = wdata_q;
        case (f3_q)
            3'b000: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                st_be   = 4'b1111;
                st_data = wdata_q;
            end
            default: st_be = 4'b0000;
        endcase
        mem_we = access & we_q & ~err;
    end

    // Storage is intentionally not reset. A reset during BUSY forces the
    // state to IDLE asynchronously, so mem_we cannot fire for an aborted store.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;

    // Instance A: default LATENCY=2
    logic        a_rst_n, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [2:0]  a_req_funct3;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;

    // Instance B: LATENCY=4, used for latency-4 timing and reset abort
    logic        b_rst_n, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [2:0]  b_req_funct3;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut_a (
        .clk        (clk),
        .reset      (a_rst_n),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_we     (a_req_we),
        .req_funct3 (a_req_funct3),
        .req_addr   (a_req_addr),
        .req_wdata  (a_req_wdata),
        .rsp_valid  (a_rsp_valid),
        .rsp_ready  (a_rsp_ready),
        .rsp_rdata  (a_rsp_rdata),
        .rsp_err    (a_rsp_err)
    );

    data_mem_responder #(.ADDR_W(10), .LATENCY(4)) dut_b (
        .clk        (clk),
        .reset      (b_rst_n),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_we     (b_req_we),
        .req_funct3 (b_req_funct3),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .rsp_valid  (b_rsp_valid),
        .rsp_ready  (b_rsp_ready),
        .rsp_rdata  (b_rsp_rdata),
        .rsp_err    (b_rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare whenever a response handshake is visible
    always @(negedge clk) begin
        if (a_rsp_valid && a_rsp_ready) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_rsp: got response 0x%08h required none", a_rsp_rdata);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_rsp_rdata", a_rsp_rdata, e.rdata);
                check("a_rsp_err", {31'd0, a_rsp_err}, {31'd0, e.err});
            end
        end
    end

    always @(negedge clk) begin
        if (b_rsp_valid && b_rsp_ready) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_rsp: got response 0x%08h required none", b_rsp_rdata);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_rsp_rdata", b_rsp_rdata, e.rdata);
                check("b_rsp_err", {31'd0, b_rsp_err}, {31'd0, e.err});
            end
        end
    end

    function automatic logic get_rv(input bit b);
        return b ? b_rsp_valid : a_rsp_valid;
    endfunction

    function automatic logic get_rr(input bit b);
        return b ? b_req_ready : a_req_ready;
    endfunction

    function automatic logic [31:0] get_rd(input bit b);
        return b ? b_rsp_rdata : a_rsp_rdata;
    endfunction

    task automatic drive(input bit b, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (b) begin
            b_req_valid = v; b_req_we = we; b_req_funct3 = f3; b_req_addr = addr; b_req_wdata = wd;
        end else begin
            a_req_valid = v; a_req_we = we; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wd;
        end
    endtask

    task automatic set_rsp_ready(input bit b, input logic v);
        if (b) b_rsp_ready = v;
        else   a_rsp_ready = v;
    endtask

    // One full transaction. hold = cycles of rsp_ready=0 after rsp_valid rises;
    // during hold a conflicting store (sw addr <- 0) is pulsed and must be ignored.
    task automatic do_req(input bit b, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int hold);
        exp_t e;
        int   cyc;
        @(posedge clk); #1;
        drive(b, 1'b1, we, f3, addr, wd);
        @(posedge clk);
        e.rdata = exp_rd;
        e.err   = exp_err;
        if (b) qb.push_back(e);
        else   qa.push_back(e);
        #1;
        drive(b, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check("req_ready_low_after_accept", {31'd0, get_rr(b)}, 32'd0);
        cyc = 0;
        while (!get_rv(b) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!get_rv(b)) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles required %0d", cyc, exp_lat);
        end else begin
            check("rsp_latency", cyc, exp_lat);
            for (int i = 0; i < hold; i++) begin
                check("hold_rsp_valid", {31'd0, get_rv(b)}, 32'd1);
                check("hold_rsp_rdata", get_rd(b), exp_rd);
                check("hold_req_ready", {31'd0, get_rr(b)}, 32'd0);
                if (i == 1) drive(b, 1'b1, 1'b1, 3'b010, addr, 32'd0);
                @(posedge clk); #1;
                drive(b, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            end
            set_rsp_ready(b, 1'b1);
            @(posedge clk); #1;
            set_rsp_ready(b, 1'b0);
            check("idle_req_ready", {31'd0, get_rr(b)}, 32'd1);
            check("idle_rsp_valid", {31'd0, get_rv(b)}, 32'd0);
        end
    endtask

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #23;
        check("reset_req_ready", {31'd0, a_req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        check("reset_rsp_rdata", a_rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, a_rsp_err}, 32'd0);
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        // Word round trip
        do_req(0, 1, LW,  32'h010, 32'hDEADBEEF, 32'h0,        0, 2, 0);
        do_req(0, 0, LW,  32'h010, 32'h0,        32'hDEADBEEF, 0, 2, 0);
        // Byte lanes
        do_req(0, 1, LW,  32'h020, 32'h00000000, 32'h0,        0, 2, 0);
        do_req(0, 1, LB,  32'h023, 32'h000000A5, 32'h0,        0, 2, 0);
        do_req(0, 0, LW,  32'h020, 32'h0,        32'hA5000000, 0, 2, 0);
        do_req(0, 0, LB,  32'h023, 32'h0,        32'hFFFFFFA5, 0, 2, 0);
        do_req(0, 0, LBU, 32'h023, 32'h0,        32'h000000A5, 0, 2, 0);
        do_req(0, 0, LB,  32'h012, 32'h0,        32'hFFFFFFAD, 0, 2, 0);
        // Halfword
        do_req(0, 1, LW,  32'h030, 32'h11223344, 32'h0,        0, 2, 0);
        do_req(0, 1, LH,  32'h032, 32'h00008001, 32'h0,        0, 2, 0);
        do_req(0, 0, LH,  32'h032, 32'h0,        32'hFFFF8001, 0, 2, 0);
        do_req(0, 0, LHU, 32'h032, 32'h0,        32'h00008001, 0, 2, 0);
        do_req(0, 0, LW,  32'h030, 32'h0,        32'h80013344, 0, 2, 0);
        do_req(0, 0, LH,  32'h010, 32'h0,        32'hFFFFBEEF, 0, 2, 0);
        do_req(0, 0, LHU, 32'h012, 32'h0,        32'h0000DEAD, 0, 2, 0);
        // Errors (first one follows a nonzero load result, so rdata must clear)
        do_req(0, 0, LW,  32'h011, 32'h0,        32'h0,        1, 2, 0);
        do_req(0, 1, LW,  32'h000, 32'hCAFEF00D, 32'h0,        0, 2, 0);
        do_req(0, 1, LW,  32'h1000, 32'h0,       32'h0,        1, 2, 0);
        do_req(0, 0, LW,  32'h000, 32'h0,        32'hCAFEF00D, 0, 2, 0);
        do_req(0, 0, 3'b011, 32'h010, 32'h0,     32'h0,        1, 2, 0);
        do_req(0, 1, 3'b011, 32'h000, 32'h0,     32'h0,        1, 2, 0);
        do_req(0, 1, LH,  32'h001, 32'hFFFF,     32'h0,        1, 2, 0);
        do_req(0, 0, LW,  32'h000, 32'h0,        32'hCAFEF00D, 0, 2, 0);
        // Backpressure with an ignored request pulse (sw 0x010 <- 0)
        do_req(0, 0, LW,  32'h010, 32'h0,        32'hDEADBEEF, 0, 2, 5);
        do_req(0, 0, LW,  32'h010, 32'h0,        32'hDEADBEEF, 0, 2, 0);

        // LATENCY=4 instance: timing, then reset abort of a pending store
        do_req(1, 1, LW,  32'h040, 32'h0BADF00D, 32'h0,        0, 4, 0);
        do_req(1, 0, LW,  32'h040, 32'h0,        32'h0BADF00D, 0, 4, 0);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, LW, 32'h040, 32'h12345678);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_rst_n = 1'b0;
        #1;
        check("abort_req_ready", {31'd0, b_req_ready}, 32'd1);
        check("abort_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
        check("abort_rsp_rdata", b_rsp_rdata, 32'd0);
        check("abort_rsp_err", {31'd0, b_rsp_err}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        do_req(1, 0, LW,  32'h040, 32'h0,        32'h0BADF00D, 0, 4, 0);

        repeat (3) @(posedge clk);
        #1;
        check("a_queue_empty", qa.size(), 32'd0);
        check("b_queue_empty", qb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's load/store port, replacing the zero-wait combinational data memory.
- Accepts one request at a time over a valid/ready handshake and inserts a programmable wait-state count.
- Performs RV32I byte, halfword and word stores with lane selection, and returns sign- or zero-extended load data.
- Flags misaligned, out-of-range and illegal-funct3 accesses with an error response.

Parameters:
- ADDR_W, 10, word-address width; storage is 2**ADDR_W 32-bit words (1024 by default).
- LATENCY, 2, cycles from the accept edge to rsp_valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 of the load/store.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (rs2).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  access rejected.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Storage contents are not cleared.
- FSM states IDLE, BUSY, RESP:
  - IDLE: req_ready=1. On req_valid=1 at a rising edge, latch we, funct3, addr and wdata, load counter=LATENCY-1, and go to BUSY. If LATENCY=1, go directly to the access edge below.
  - BUSY: req_ready=0. Decrement the counter each cycle. The edge on which the counter is 0 is the access edge: perform the store or read, register rsp_rdata/rsp_err, and go to RESP.
  - RESP: rsp_valid=1, req_ready=0. Outputs hold stable while rsp_ready=0. On rsp_ready=1, go to IDLE, drop rsp_valid, and leave rsp_rdata/rsp_err unchanged.
- Timing:
  - rsp_valid rises exactly LATENCY cycles after the accept edge.
  - The earliest next accept is one cycle after the response handshake. There is no back-to-back overlap; req_valid seen in RESP is ignored.
- Decode:
  - Word index = addr[ADDR_W+1:2]; lane = addr[1:0].
  - Out-of-range if addr[31:ADDR_W+2] != 0.
- Loads (req_we=0):
  - 000 lb: byte at lane, sign-extended.
  - 001 lh: half at addr[1], sign-extended.
  - 010 lw: full word.
  - 100 lbu, 101 lhu: zero-extended versions of lb and lh.
  - 011, 110, 111: error.
- Stores (req_we=1):
  - 000 sb: wdata[7:0] into the lane.
  - 001 sh: wdata[15:0] into bytes {2*addr[1]+1, 2*addr[1]}.
  - 010 sw: the whole word.
  - Other funct3 values: error.
  - Unwritten bytes keep their value. rsp_rdata=0.
- Errors:
  - Causes: misaligned (half with addr[0]=1; word with addr[1:0]!=0), out-of-range, or illegal funct3.
  - Result: rsp_err=1, rsp_rdata=0, and no storage write.
- Request inputs are don't-care outside IDLE; only latched copies are used.
- Reset mid-operation:
  - Reset in BUSY aborts the pending store; storage is unchanged.
  - Reset in RESP discards the response.
  - Either way the block returns to IDLE.
- Storage reads are a registered snapshot at the access edge, with no read-during-write hazard, since one access is in flight.

Test Plan:
- Word round-trip: sw addr 0x010 data 0xDEADBEEF, then lw 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid rises exactly 2 cycles after each accept.
- Byte lanes: sw 0x020=0x00000000, sb 0x023 data 0x000000A5, then lw 0x020 -> 0xA5000000. Also lb 0x023 -> 0xFFFFFFA5 and lbu 0x023 -> 0x000000A5.
- Halfword: sh 0x032 data 0x00008001, then lh 0x032 -> 0xFFFF8001, lhu 0x032 -> 0x00008001, lw 0x030 shows only the upper half changed.
- Errors:
  - lw 0x011 -> rsp_err=1, rsp_rdata=0.
  - sw 0x1000 (out of range, ADDR_W=10) -> rsp_err=1, and lw 0x000 is unchanged.
  - Load funct3=011 -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay constant, req_ready=0, and a req_valid pulse is ignored; raise rsp_ready -> IDLE the next cycle.
- Reset abort: sw 0x040=0x12345678 accepted with LATENCY=4, then reset pulsed low on cycle 2 -> outputs are immediately at reset values, and a later lw 0x040 returns the prior contents.
